// File: rtl/alu_issue_pkg.sv
// Shared RV32I decode constants and ALU opcode encoding for the issue stage and the ALU.
package alu_issue_pkg;

  localparam logic [3:0] ALU_OPCODE_ADD = 4'd0;
  localparam logic [3:0] ALU_OPCODE_SUB = 4'd1;
  localparam logic [3:0] ALU_OPCODE_AND = 4'd2;
  localparam logic [3:0] ALU_OPCODE_OR  = 4'd3;
  localparam logic [3:0] ALU_OPCODE_XOR = 4'd4;
  localparam logic [3:0] ALU_OPCODE_SLT = 4'd5;
  localparam logic [3:0] ALU_OPCODE_SLL = 4'd6;
  localparam logic [3:0] ALU_OPCODE_SRL = 4'd7;
  localparam logic [3:0] ALU_OPCODE_SRA = 4'd8;
  localparam logic [3:0] ALU_OPCODE_LUI = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JUMP = 2'b11;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       reg_write;
    logic [1:0] branch;
    logic       illegal;
  } ctl_t;

  // alt picks SUB over ADD and SRA over SRL; SLTU shares the SLT opcode.
  function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_OPCODE_SUB : ALU_OPCODE_ADD;
      F3_SLL:  return ALU_OPCODE_SLL;
      F3_SLT:  return ALU_OPCODE_SLT;
      F3_SLTU: return ALU_OPCODE_SLT;
      F3_XOR:  return ALU_OPCODE_XOR;
      F3_SR:   return alt ? ALU_OPCODE_SRA : ALU_OPCODE_SRL;
      F3_OR:   return ALU_OPCODE_OR;
      default: return ALU_OPCODE_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Decode-side request, EX-side result and writeback snoop signals of the issue stage.
interface alu_issue_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               instr;
  logic [DATA_WIDTH-1:0]     pc;
  logic [DATA_WIDTH-1:0]     rs1_data;
  logic [DATA_WIDTH-1:0]     rs2_data;
  logic                      flush;
  logic                      ex_ready;
  logic                      ex_valid;
  logic [DATA_WIDTH-1:0]     ALUop1;
  logic [DATA_WIDTH-1:0]     ALUop2;
  logic [3:0]                ALUctrl;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic                      reg_write;
  logic [1:0]                branch;
  logic                      illegal;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic                      wb_we;

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, flush, ex_ready, wb_rd, wb_data, wb_we,
    input  in_ready, ex_valid, ALUop1, ALUop2, ALUctrl, rd, reg_write, branch, illegal
  );

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, flush, ex_ready, wb_rd, wb_data, wb_we,
    output in_ready, ex_valid, ALUop1, ALUop2, ALUctrl, rd, reg_write, branch, illegal
  );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode into ALU control word and operand pair.
module alu_issue_decode
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [31:0]               instr,
  input  logic [DATA_WIDTH-1:0]     pc,
  input  logic [DATA_WIDTH-1:0]     rs1_data,
  input  logic [DATA_WIDTH-1:0]     rs2_data,
  output ctl_t                      ctl,
  output logic [DATA_WIDTH-1:0]     op1,
  output logic [DATA_WIDTH-1:0]     op2,
  output logic [REG_ADDR_WIDTH-1:0] rd
);

  logic [6:0]            opcode;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic                  is_shift;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_s;

  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign rd       = REG_ADDR_WIDTH'(instr[11:7]);
  assign is_shift = (f3 == F3_SLL) || (f3 == F3_SR);
  assign imm_i    = DATA_WIDTH'($signed(instr[31:20]));
  assign imm_s    = DATA_WIDTH'($signed({instr[31:25], instr[11:7]}));

  // Illegal encodings fall through with operands left at zero.
  always_comb begin
    ctl = '{ctrl: ALU_OPCODE_ADD, reg_write: 1'b0, branch: BR_NONE, illegal: 1'b0};
    op1 = '0;
    op2 = '0;
    case (opcode)
      OPC_OP: begin
        if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))) begin
          ctl.ctrl      = alu_f3(f3, f7 == F7_ALT);
          ctl.reg_write = 1'b1;
          op1           = rs1_data;
          op2           = is_shift ? DATA_WIDTH'(rs2_data[4:0]) : rs2_data;
        end else begin
          ctl.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        ctl.ctrl      = alu_f3(f3, (f3 == F3_SR) && instr[30]);
        ctl.reg_write = 1'b1;
        op1           = rs1_data;
        op2           = is_shift ? DATA_WIDTH'(instr[24:20]) : imm_i;
      end
      OPC_LUI: begin
        ctl.ctrl      = ALU_OPCODE_LUI;
        ctl.reg_write = 1'b1;
        op2           = DATA_WIDTH'(instr[31:12]);
      end
      OPC_AUIPC: begin
        ctl.reg_write = 1'b1;
        op1           = pc;
        op2           = DATA_WIDTH'({instr[31:12], 12'b0});
      end
      OPC_LOAD: begin
        ctl.reg_write = 1'b1;
        op1           = rs1_data;
        op2           = imm_i;
      end
      OPC_STORE: begin
        op1 = rs1_data;
        op2 = imm_s;
      end
      OPC_BRANCH: begin
        if (f3 == F3_BEQ || f3 == F3_BNE) begin
          ctl.ctrl   = ALU_OPCODE_SUB;
          ctl.branch = (f3 == F3_BEQ) ? BR_BEQ : BR_BNE;
          op1        = rs1_data;
          op2        = rs2_data;
        end else begin
          ctl.illegal = 1'b1;
        end
      end
      OPC_JAL, OPC_JALR: begin
        ctl.reg_write = 1'b1;
        ctl.branch    = BR_JUMP;
        op1           = pc;
        op2           = DATA_WIDTH'(32'd4);
      end
      default: ctl.illegal = 1'b1;
    endcase
    if (instr[11:7] == 5'd0) ctl.reg_write = 1'b0;
  end

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: 1-cycle registered decode, holds while EX stalls, flush kills the entry.
// ALU_ISSUE_FWD_EN: substitute writeback data for matching rs1/rs2 at capture.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic        clk,
  input logic        rst,
  alu_issue_if.slave bus
);

  logic [DATA_WIDTH-1:0]     rs1_eff;
  logic [DATA_WIDTH-1:0]     rs2_eff;
  ctl_t                      dec_ctl;
  logic [DATA_WIDTH-1:0]     dec_op1;
  logic [DATA_WIDTH-1:0]     dec_op2;
  logic [REG_ADDR_WIDTH-1:0] dec_rd;

  logic                      ex_valid_q;
  ctl_t                      ctl_q;
  logic [DATA_WIDTH-1:0]     op1_q;
  logic [DATA_WIDTH-1:0]     op2_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      in_ready_c;

`ifdef ALU_ISSUE_FWD_EN
  logic [REG_ADDR_WIDTH-1:0] rs1_idx;
  logic [REG_ADDR_WIDTH-1:0] rs2_idx;

  assign rs1_idx = REG_ADDR_WIDTH'(bus.instr[19:15]);
  assign rs2_idx = REG_ADDR_WIDTH'(bus.instr[24:20]);
  assign rs1_eff = (bus.wb_we && bus.wb_rd != '0 && bus.wb_rd == rs1_idx) ? bus.wb_data : bus.rs1_data;
  assign rs2_eff = (bus.wb_we && bus.wb_rd != '0 && bus.wb_rd == rs2_idx) ? bus.wb_data : bus.rs2_data;
`else
  logic unused_wb;

  assign rs1_eff   = bus.rs1_data;
  assign rs2_eff   = bus.rs2_data;
  assign unused_wb = &{1'b0, bus.wb_we, bus.wb_rd, bus.wb_data};
`endif

  alu_issue_decode #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_decode (
    .instr    (bus.instr),
    .pc       (bus.pc),
    .rs1_data (rs1_eff),
    .rs2_data (rs2_eff),
    .ctl      (dec_ctl),
    .op1      (dec_op1),
    .op2      (dec_op2),
    .rd       (dec_rd)
  );

  assign in_ready_c = !ex_valid_q || bus.ex_ready;

  // Flush only kills the valid bit; data registers keep whatever they held.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ctl_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      rd_q       <= '0;
    end else if (bus.flush) begin
      ex_valid_q <= 1'b0;
    end else if (in_ready_c) begin
      ex_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        ctl_q <= dec_ctl;
        op1_q <= dec_op1;
        op2_q <= dec_op2;
        rd_q  <= dec_rd;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ALUop1    = op1_q;
  assign bus.ALUop2    = op2_q;
  assign bus.ALUctrl   = ctl_q.ctrl;
  assign bus.rd        = rd_q;
  assign bus.reg_write = ctl_q.reg_write;
  assign bus.branch    = ctl_q.branch;
  assign bus.illegal   = ctl_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed table of RV32I encodings plus stall/flush/reset/forwarding sequences for alu_issue.
module tb_alu_issue;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_issue_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  alu_issue #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  br;
    logic        ill;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [76:0] outs();
    return {bus.ALUctrl, bus.ALUop1, bus.ALUop2, bus.rd, bus.reg_write, bus.branch, bus.illegal};
  endfunction

  function automatic logic [76:0] expv(input vec_t v);
    return {v.ctrl, v.op1, v.op2, v.rd, v.rw, v.br, v.ill};
  endfunction

  task automatic drive(input vec_t v);
    bus.instr    = v.instr;
    bus.pc       = v.pc;
    bus.rs1_data = v.rs1;
    bus.rs2_data = v.rs2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] fwd1;
    logic [31:0] fwd2;
    //          name      instr         pc            rs1           rs2           ctrl  op1           op2           rd     rw    br     ill
    vecs[0]  = '{"addi",  32'hFFD08293, 32'h0,        32'd10,       32'h0,        4'd0, 32'd10,       32'hFFFFFFFD, 5'd5,  1'b1, 2'b00, 1'b0};
    vecs[1]  = '{"lui",   32'h123451B7, 32'h0,        32'h1,        32'h2,        4'd9, 32'h0,        32'h00012345, 5'd3,  1'b1, 2'b00, 1'b0};
    vecs[2]  = '{"srai",  32'h4030D113, 32'h0,        32'h80000000, 32'h0,        4'd8, 32'h80000000, 32'd3,        5'd2,  1'b1, 2'b00, 1'b0};
    vecs[3]  = '{"beq",   32'h00208463, 32'h0,        32'h11,       32'h22,       4'd1, 32'h11,       32'h22,       5'd8,  1'b0, 2'b01, 1'b0};
    vecs[4]  = '{"mul",   32'h02208033, 32'h0,        32'h3,        32'h4,        4'd0, 32'h0,        32'h0,        5'd0,  1'b0, 2'b00, 1'b1};
    vecs[5]  = '{"add",   32'h00208233, 32'h0,        32'd7,        32'd9,        4'd0, 32'd7,        32'd9,        5'd4,  1'b1, 2'b00, 1'b0};
    vecs[6]  = '{"sub",   32'h40208233, 32'h0,        32'd20,       32'd5,        4'd1, 32'd20,       32'd5,        5'd4,  1'b1, 2'b00, 1'b0};
    vecs[7]  = '{"sll",   32'h00209333, 32'h0,        32'h1,        32'h123,      4'd6, 32'h1,        32'd3,        5'd6,  1'b1, 2'b00, 1'b0};
    vecs[8]  = '{"sltu",  32'h0020B3B3, 32'h0,        32'h5,        32'h6,        4'd5, 32'h5,        32'h6,        5'd7,  1'b1, 2'b00, 1'b0};
    vecs[9]  = '{"sra",   32'h4020D2B3, 32'h0,        32'hF0000000, 32'hFFFFFFE4, 4'd8, 32'hF0000000, 32'd4,        5'd5,  1'b1, 2'b00, 1'b0};
    vecs[10] = '{"auipc", 32'hABCDE517, 32'h1000,     32'h9,        32'h9,        4'd0, 32'h1000,     32'hABCDE000, 5'd10, 1'b1, 2'b00, 1'b0};
    vecs[11] = '{"lw",    32'hFFC12403, 32'h0,        32'h100,      32'h0,        4'd0, 32'h100,      32'hFFFFFFFC, 5'd8,  1'b1, 2'b00, 1'b0};
    vecs[12] = '{"sw",    32'h00312623, 32'h0,        32'h200,      32'h77,       4'd0, 32'h200,      32'd12,       5'd12, 1'b0, 2'b00, 1'b0};
    vecs[13] = '{"jal",   32'h008000EF, 32'h2000,     32'h0,        32'h0,        4'd0, 32'h2000,     32'd4,        5'd1,  1'b1, 2'b11, 1'b0};
    vecs[14] = '{"jalr0", 32'h00008067, 32'h3000,     32'h44,       32'h0,        4'd0, 32'h3000,     32'd4,        5'd0,  1'b0, 2'b11, 1'b0};
    vecs[15] = '{"nop",   32'h00000013, 32'h0,        32'h0,        32'h0,        4'd0, 32'h0,        32'h0,        5'd0,  1'b0, 2'b00, 1'b0};
    vecs[16] = '{"blt",   32'h0020C463, 32'h0,        32'h1,        32'h2,        4'd0, 32'h0,        32'h0,        5'd8,  1'b0, 2'b00, 1'b1};
    vecs[17] = '{"xori",  32'h7FF0C493, 32'h0,        32'hAA,       32'h0,        4'd4, 32'hAA,       32'h7FF,      5'd9,  1'b1, 2'b00, 1'b0};
    vecs[18] = '{"slli",  32'h01F09093, 32'h0,        32'h1,        32'h0,        4'd6, 32'h1,        32'd31,       5'd1,  1'b1, 2'b00, 1'b0};
    vecs[19] = '{"badop", 32'h0000007F, 32'h0,        32'h5,        32'h5,        4'd0, 32'h0,        32'h0,        5'd0,  1'b0, 2'b00, 1'b1};

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    bus.instr    = 32'hFFD08293;
    bus.pc       = 32'h0;
    bus.rs1_data = 32'hFFFF;
    bus.rs2_data = 32'hFFFF;
    bus.wb_rd    = 5'd0;
    bus.wb_data  = 32'h0;
    bus.wb_we    = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    tick();
    chk("reset_outs", 128'(outs()), 128'(0));
    chk("reset_ex_valid", 128'(bus.ex_valid), 128'(0));
    chk("reset_in_ready", 128'(bus.in_ready), 128'(1));
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      bus.in_valid = 1'b1;
      tick();
      chk({vecs[i].name, "_valid"}, 128'(bus.ex_valid), 128'(1));
      chk(vecs[i].name, 128'(outs()), 128'(expv(vecs[i])));
    end

    // Stall: BEQ held for three cycles while ADDI waits at the input.
    drive(vecs[3]);
    tick();
    bus.ex_ready = 1'b0;
    drive(vecs[0]);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
      tick();
      chk("stall_hold", 128'(outs()), 128'(expv(vecs[3])));
      chk("stall_valid", 128'(bus.ex_valid), 128'(1));
    end
    bus.ex_ready = 1'b1;
    #1;
    chk("release_in_ready", 128'(bus.in_ready), 128'(1));
    tick();
    chk("release_capture", 128'(outs()), 128'(expv(vecs[0])));
    chk("release_valid", 128'(bus.ex_valid), 128'(1));

    bus.in_valid = 1'b0;
    tick();
    chk("idle_valid", 128'(bus.ex_valid), 128'(0));

    // Flush while stalled drops the buffered entry.
    drive(vecs[1]);
    bus.in_valid = 1'b1;
    tick();
    bus.ex_ready = 1'b0;
    bus.flush    = 1'b1;
    tick();
    chk("flush_stall_valid", 128'(bus.ex_valid), 128'(0));

    // Flush together with an incoming instruction: nothing captured.
    bus.ex_ready = 1'b1;
    drive(vecs[2]);
    tick();
    chk("flush_in_valid", 128'(bus.ex_valid), 128'(0));
    bus.flush = 1'b0;

    // Reset mid-stream clears every output.
    drive(vecs[0]);
    tick();
    chk("pre_rst_valid", 128'(bus.ex_valid), 128'(1));
    rst = 1'b1;
    tick();
    chk("midrst_outs", 128'(outs()), 128'(0));
    chk("midrst_valid", 128'(bus.ex_valid), 128'(0));
    rst = 1'b0;

`ifdef ALU_ISSUE_FWD_EN
    fwd1 = 32'h55;
    fwd2 = 32'h77;
`else
    fwd1 = 32'h0;
    fwd2 = 32'h66;
`endif
    // ADD x4,x1,x2 with writeback to x1.
    bus.instr    = 32'h00208233;
    bus.rs1_data = 32'h0;
    bus.rs2_data = 32'h66;
    bus.wb_we    = 1'b1;
    bus.wb_rd    = 5'd1;
    bus.wb_data  = 32'h55;
    tick();
    chk("fwd_rs1", 128'(bus.ALUop1), 128'(fwd1));
    chk("fwd_rs1_op2", 128'(bus.ALUop2), 128'(32'h66));

    // Writeback to x2 hits rs2 only.
    bus.wb_rd   = 5'd2;
    bus.wb_data = 32'h77;
    tick();
    chk("fwd_rs2", 128'(bus.ALUop2), 128'(fwd2));
    chk("fwd_rs2_op1", 128'(bus.ALUop1), 128'(32'h0));

    // ADD x4,x0,x2 with writeback to x0: never forwarded.
    bus.instr   = 32'h00200233;
    bus.wb_rd   = 5'd0;
    bus.wb_data = 32'h55;
    tick();
    chk("fwd_x0", 128'(bus.ALUop1), 128'(32'h0));

    // Writeback disabled.
    bus.instr = 32'h00208233;
    bus.wb_we = 1'b0;
    bus.wb_rd = 5'd1;
    tick();
    chk("fwd_we0", 128'(bus.ALUop1), 128'(32'h0));

    bus.in_valid = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
